rsa_exp_ctrl: RTL and testbench

RSA_EXP_CTRL -- requirements
Module: rsa_exp_ctrl

---
 rtl/rsa_exp_if.sv | 13 +
 rtl/rsa_exp_ctrl.sv | 158 +++++++++++++++
 tb/tb_rsa_exp_ctrl.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/rsa_exp_if.sv
// rsa_exp_if: batch handshake between an RSA ciphertext source and rsa_exp_ctrl.
interface rsa_exp_if #(parameter int WIDTH = 4);
    logic                 in_valid;
    logic [WIDTH-1:0]     in_p;
    logic [WIDTH-1:0]     in_q;
    logic [2*WIDTH-1:0]   in_e;
    logic [2*WIDTH-1:0]   in_c;
    logic                 out_valid;
    logic [2*WIDTH-1:0]   out_m;
    logic                 busy;
    modport master(output in_valid, in_p, in_q, in_e, in_c, input out_valid, out_m, busy);
    modport slave(input in_valid, in_p, in_q, in_e, in_c, output out_valid, out_m, busy);
endinterface

// File: rtl/rsa_exp_ctrl.sv
// rsa_exp_ctrl: buffers 8 ciphertext words, decrypts each by LSB-first square-and-multiply, replays them.
// Optional key validity check is enabled with the RSA_CTRL_KEYCHK_EN macro.
module RSA_IP #(parameter int WIDTH = 4) (
    input  logic [WIDTH-1:0]   p_i,
    input  logic [WIDTH-1:0]   q_i,
    input  logic [2*WIDTH-1:0] e_i,
    output logic [2*WIDTH-1:0] n_o,
    output logic [2*WIDTH-1:0] d_o
);
    localparam int W2 = 2 * WIDTH;
    logic [W2-1:0]   phi, dv;
    logic [2*W2-1:0] prod;
    // D is the smallest inverse of E modulo phi, or 0 when none exists
    always_comb begin
        n_o  = {{WIDTH{1'b0}}, p_i} * {{WIDTH{1'b0}}, q_i};
        phi  = ({{WIDTH{1'b0}}, p_i} - W2'(1)) * ({{WIDTH{1'b0}}, q_i} - W2'(1));
        d_o  = '0;
        dv   = '0;
        prod = '0;
        for (int i = 2**W2 - 1; i > 0; i--) begin
            dv   = W2'(i);
            prod = ({{W2{1'b0}}, dv} * {{W2{1'b0}}, e_i}) % {{W2{1'b0}}, (phi == '0) ? W2'(1) : phi};
            if (dv < phi && prod == (2*W2)'(1)) d_o = dv;
        end
    end
endmodule

module rsa_exp_ctrl #(parameter int WIDTH = 4) (
    input logic clk,
    input logic rst_n,
    rsa_exp_if.slave bus
);
    localparam int W2 = 2 * WIDTH;
    localparam int W4 = 4 * WIDTH;
    localparam int BW = $clog2(W2);
    typedef enum logic [2:0] {IDLE, LOAD, KEY, INIT, EXP, OUT} state_t;
    state_t            state_q, state_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [BW-1:0]     bit_q, bit_d;
    logic [WIDTH-1:0]  p_q, p_d, q_q, q_d;
    logic [W2-1:0]     e_q, e_d, n_q, n_d, d_q, d_d, base_q, base_d, acc_q, acc_d;
    logic [W2-1:0]     mem_q [8];
    logic [W2-1:0]     mem_d [8];
    logic [W2-1:0]     n_ip, d_ip;
    logic [W4-1:0]     nmod, sq, mul, cmod;
    logic              key_ok;

    RSA_IP #(WIDTH) u_ip (.p_i(p_q), .q_i(q_q), .e_i(e_q), .n_o(n_ip), .d_o(d_ip));

    // N of 0 would divide by zero; reducing by 1 instead yields the required all-zero results
    assign nmod = {{W2{1'b0}}, (n_q == '0) ? W2'(1) : n_q};
    assign sq   = ({{W2{1'b0}}, base_q} * {{W2{1'b0}}, base_q}) % nmod;
    assign mul  = ({{W2{1'b0}}, acc_q} * {{W2{1'b0}}, base_q}) % nmod;
    assign cmod = {{W2{1'b0}}, mem_q[cnt_q]} % nmod;

`ifdef RSA_CTRL_KEYCHK_EN
    logic          key_ok_q, key_ok_d;
    logic [W2-1:0] phi;
    logic [W4-1:0] de;
    assign phi = ({{WIDTH{1'b0}}, p_q} - W2'(1)) * ({{WIDTH{1'b0}}, q_q} - W2'(1));
    assign de  = ({{W2{1'b0}}, d_ip} * {{W2{1'b0}}, e_q}) % {{W2{1'b0}}, (phi == '0) ? W2'(1) : phi};
    assign key_ok_d = (state_q == KEY) ? (e_q != '0 && e_q < phi && de == W4'(1)) : key_ok_q;
    assign key_ok   = key_ok_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) key_ok_q <= 1'b0;
        else        key_ok_q <= key_ok_d;
    end
`else
    assign key_ok = 1'b1;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        p_d     = p_q;
        q_d     = q_q;
        e_d     = e_q;
        n_d     = n_q;
        d_d     = d_q;
        base_d  = base_q;
        acc_d   = acc_q;
        mem_d   = mem_q;
        case (state_q)
            IDLE: if (bus.in_valid) begin
                p_d      = bus.in_p;
                q_d      = bus.in_q;
                e_d      = bus.in_e;
                mem_d[0] = bus.in_c;
                cnt_d    = 3'd1;
                state_d  = LOAD;
            end
            LOAD: if (bus.in_valid) begin
                mem_d[cnt_q] = bus.in_c;
                cnt_d        = cnt_q + 3'd1;
                state_d      = (cnt_q == 3'd7) ? KEY : LOAD;
            end
            KEY: begin
                n_d     = n_ip;
                d_d     = d_ip;
                state_d = INIT;
            end
            INIT: begin
                base_d  = W2'(cmod);
                acc_d   = (n_q <= W2'(1)) ? '0 : W2'(1);
                bit_d   = '0;
                state_d = EXP;
            end
            EXP: begin
                acc_d  = d_q[bit_q] ? W2'(mul) : acc_q;
                base_d = W2'(sq);
                bit_d  = bit_q + 1'b1;
                if (bit_q == BW'(W2 - 1)) begin
                    mem_d[cnt_q] = acc_d;
                    cnt_d        = cnt_q + 3'd1;
                    state_d      = (cnt_q == 3'd7) ? OUT : INIT;
                end
            end
            OUT: begin
                cnt_d   = cnt_q + 3'd1;
                state_d = (cnt_q == 3'd7) ? IDLE : OUT;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            p_q     <= '0;
            q_q     <= '0;
            e_q     <= '0;
            n_q     <= '0;
            d_q     <= '0;
            base_q  <= '0;
            acc_q   <= '0;
            mem_q   <= '{default: '0};
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            p_q     <= p_d;
            q_q     <= q_d;
            e_q     <= e_d;
            n_q     <= n_d;
            d_q     <= d_d;
            base_q  <= base_d;
            acc_q   <= acc_d;
            mem_q   <= mem_d;
        end
    end

    assign bus.out_valid = (state_q == OUT);
    assign bus.out_m     = (state_q == OUT && key_ok) ? mem_q[cnt_q] : '0;
    assign bus.busy      = (state_q != IDLE) || bus.in_valid;
endmodule

// File: tb/tb_rsa_exp_ctrl.sv
// tb_rsa_exp_ctrl: randomized and directed batches scored against an arithmetic RSA model.
module tb_rsa_exp_ctrl;
    localparam int WIDTH = 4;
    localparam int MASK  = 255;
    localparam int LAT   = 74;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    rsa_exp_if #(.WIDTH(WIDTH)) bus();
    rsa_exp_ctrl #(.WIDTH(WIDTH)) dut(.clk(clk), .rst_n(rst_n), .bus(bus));

    int checks = 0;
    int failures = 0;
    int ncyc = 0;
    int outs = 0;
    int exp_q[$];
    int lat_q[$];
    bit prev_ov = 1'b0;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, req, ncyc);
        end
    endtask

    function automatic int inv(input int e, input int phi);
        for (int d = 1; d < phi; d++) if ((d * e) % phi == 1) return d;
        return 0;
    endfunction

    function automatic int modpow(input int c, input int d, input int n);
        int r;
        if (n <= 1) return 0;
        r = 1 % n;
        for (int i = 0; i < d; i++) r = (r * (c % n)) % n;
        return r;
    endfunction

    always @(negedge clk) begin
        ncyc++;
        if (!rst_n) prev_ov = 1'b0;
        else if (bus.out_valid) begin
            outs++;
            if (exp_q.size() == 0) check("unexpected_out_valid", 1, 0);
            else check("out_m", int'(bus.out_m), exp_q.pop_front());
            check("busy_during_out", int'(bus.busy), 1);
            if (!prev_ov && lat_q.size() != 0) check("latency", ncyc, lat_q.pop_front());
            prev_ov = 1'b1;
        end else begin
            check("out_m_idle", int'(bus.out_m), 0);
            prev_ov = 1'b0;
        end
    end

    task automatic send(input int p, input int q, input int e, input int c[8]);
        int n, phi, d;
        bit bad;
        n   = p * q;
        phi = ((p - 1) * (q - 1)) & MASK;
        d   = inv(e, phi);
        bad = 1'b0;
`ifdef RSA_CTRL_KEYCHK_EN
        bad = (e == 0) || (e >= phi) || (phi == 0 ? 1'b1 : ((d * e) % phi) != 1);
`endif
        for (int k = 0; k < 8; k++) exp_q.push_back(bad ? 0 : modpow(c[k], d, n));
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            bus.in_valid = 1'b1;
            bus.in_p = (k == 0) ? WIDTH'(p) : WIDTH'($urandom);
            bus.in_q = (k == 0) ? WIDTH'(q) : WIDTH'($urandom);
            bus.in_e = (k == 0) ? 8'(e) : 8'($urandom);
            bus.in_c = 8'(c[k]);
            if (k == 0) begin
                @(negedge clk);
                check("busy_start", int'(bus.busy), 1);
            end
        end
        @(negedge clk); #1;
        lat_q.push_back(ncyc + LAT);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.in_c = 8'($urandom);
    endtask

    task automatic wait_done();
        int t = 0;
        while (exp_q.size() != 0 && t < 2000) begin
            @(negedge clk);
            t++;
        end
        if (exp_q.size() != 0) begin
            check("drain_timeout", exp_q.size(), 0);
            exp_q.delete();
            lat_q.delete();
        end
    endtask

    task automatic wait_last_out();
        int t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!bus.out_valid && t < 300);
        if (!bus.out_valid) check("out_valid_timeout", 0, 1);
        repeat (7) @(negedge clk);
    endtask

    initial begin
        int c29[8] = '{8, 2, 0, 1, 32, 29, 8, 2};
        int c30[8] = '{3, 0, 1, 34, 3, 3, 3, 3};
        int cr[8];
        int primes[6] = '{2, 3, 5, 7, 11, 13};
        int o0;
        bus.in_valid = 1'b0;
        bus.in_p = '0;
        bus.in_q = '0;
        bus.in_e = '0;
        bus.in_c = '0;
        repeat (3) @(negedge clk);
        check("rst_out_valid", int'(bus.out_valid), 0);
        check("rst_out_m", int'(bus.out_m), 0);
        check("rst_busy", int'(bus.busy), 0);
        @(posedge clk); #1 rst_n = 1'b1;

        send(3, 11, 3, c29);
        wait_done();

        send(3, 11, 3, c29);
        repeat (30) @(posedge clk);
        #1;
        for (int i = 0; i < 5; i++) begin
            bus.in_valid = 1'b1;
            bus.in_p = WIDTH'($urandom);
            bus.in_q = WIDTH'($urandom);
            bus.in_e = 8'($urandom);
            bus.in_c = 8'($urandom);
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
        wait_done();

        send(3, 11, 3, c29);
        repeat (25) @(posedge clk);
        #1 rst_n = 1'b0;
        exp_q.delete();
        lat_q.delete();
        @(negedge clk);
        check("midrst_out_valid", int'(bus.out_valid), 0);
        check("midrst_busy", int'(bus.busy), 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        o0 = outs;
        repeat (90) @(negedge clk);
        check("no_stale_out", outs - o0, 0);
        send(5, 7, 5, c30);
        wait_done();

        send(3, 11, 3, c29);
        wait_last_out();
        send(5, 7, 5, c30);
        wait_done();

        send(3, 11, 4, c29);
        wait_done();
        send(1, 1, 3, c30);
        wait_done();
        send(0, 5, 7, c29);
        wait_done();

        for (int r = 0; r < 6; r++) begin
            for (int k = 0; k < 8; k++) cr[k] = $urandom_range(0, 255);
            send(primes[$urandom_range(0, 5)], primes[$urandom_range(0, 5)], $urandom_range(0, 40), cr);
            wait_done();
        end
        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
